// File: rtl/router_rd_ctrl.sv
// ---------------------------------------------------------------------------
// router_rd_ctrl
//
// Destination-side read controller for one router output port. It pops a
// packet (header byte, payload bytes, parity byte) out of the port FIFO,
// streams the payload to a downstream sink and checks the packet parity.
// A soft_reset from the synchronizer drops the packet in progress.
//
// Optional feature:
//   ROUTER_RD_WDOG_EN  when defined, adds a stall watchdog that raises
//                      stall_warn when the FIFO has data but nothing has
//                      been read for WAIT_CYC-1 consecutive cycles.
//                      When undefined, stall_warn is tied low.
//
// Parameters:
//   DATA_W    FIFO / packet byte width
//   WAIT_CYC  synchronizer soft-reset window (watchdog threshold source)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   vld_out      in   port FIFO non-empty
//   soft_reset   in   port soft reset from the synchronizer
//   data_in      in   FIFO dout, valid the cycle after rd_en
//   sink_ready   in   downstream can take a byte this cycle
//   rd_en        out  FIFO read enable (combinational)
//   pkt_data     out  payload byte
//   pkt_data_vld out  one-cycle strobe per payload byte
//   pkt_start    out  one-cycle pulse when the header is accepted
//   addr_out     out  header[1:0], held until the next header
//   len_out      out  header[7:2] payload length, held until the next header
//   pkt_done     out  one-cycle pulse when the parity byte is consumed
//   parity_err   out  valid with pkt_done: computed parity != received parity
//   pkt_abort    out  one-cycle pulse when soft_reset drops a packet
//   stall_warn   out  watchdog warning level
// ---------------------------------------------------------------------------
module router_rd_ctrl #(
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_out,
  input  logic              soft_reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sink_ready,
  output logic              rd_en,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_data_vld,
  output logic              pkt_start,
  output logic [1:0]        addr_out,
  output logic [5:0]        len_out,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              pkt_abort,
  output logic              stall_warn
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t            state;
  logic [6:0]        issued;
  logic [6:0]        rcvd;
  logic              rd_pend;
  logic [DATA_W-1:0] parity_acc;
  logic              rd_allowed;
  logic [6:0]        len_ext;
  logic [6:0]        reads_needed;

  // A packet body is len_out payload bytes followed by one parity byte, so
  // BODY needs len_out+1 reads in total. Widened to 7 bits so a length of
  // 63 gives 64 without wrapping.
  assign len_ext      = {1'b0, len_out};
  assign reads_needed = len_ext + 7'd1;

  // Per-state read permission. IDLE allows exactly one read (the header)
  // because the state moves on as soon as it is issued; HDR leaves a bubble
  // while the header is decoded; BODY reads until the whole body is issued.
  always_comb begin
    rd_allowed = 1'b0;
    case (state)
      IDLE:    rd_allowed = 1'b1;
      HDR:     rd_allowed = 1'b0;
      BODY:    rd_allowed = (issued < reads_needed);
      default: rd_allowed = 1'b0;
    endcase
  end

  // The FIFO read is issued combinationally so a byte can be requested every
  // cycle; soft_reset blocks any new read in every state.
  assign rd_en = vld_out & sink_ready & ~soft_reset & rd_allowed;

  // Main packet FSM. rd_pend tracks the one-cycle FIFO latency: data_in is
  // only meaningful in the cycle after a read. Bytes already in flight are
  // always consumed, even when sink_ready or vld_out drop. soft_reset in
  // HDR/BODY wins over any byte processing and discards the in-flight byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      issued       <= '0;
      rcvd         <= '0;
      rd_pend      <= 1'b0;
      parity_acc   <= '0;
      pkt_data     <= '0;
      pkt_data_vld <= 1'b0;
      pkt_start    <= 1'b0;
      addr_out     <= '0;
      len_out      <= '0;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
      pkt_abort    <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      pkt_data_vld <= 1'b0;
      pkt_start    <= 1'b0;
      pkt_done     <= 1'b0;
      parity_err   <= 1'b0;
      pkt_abort    <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_en) begin
            state <= HDR;
          end
        end

        HDR: begin
          if (soft_reset) begin
            state     <= IDLE;
            pkt_abort <= 1'b1;
            issued    <= '0;
            rcvd      <= '0;
            rd_pend   <= 1'b0;
          end else begin
            addr_out   <= data_in[1:0];
            len_out    <= data_in[7:2];
            parity_acc <= data_in;
            issued     <= '0;
            rcvd       <= '0;
            pkt_start  <= 1'b1;
            state      <= BODY;
          end
        end

        BODY: begin
          if (soft_reset) begin
            state     <= IDLE;
            pkt_abort <= 1'b1;
            issued    <= '0;
            rcvd      <= '0;
            rd_pend   <= 1'b0;
          end else begin
            if (rd_en) begin
              issued <= issued + 7'd1;
            end
            if (rd_pend) begin
              if (rcvd < len_ext) begin
                pkt_data     <= data_in;
                pkt_data_vld <= 1'b1;
                parity_acc   <= parity_acc ^ data_in;
                rcvd         <= rcvd + 7'd1;
              end else begin
                pkt_done   <= 1'b1;
                parity_err <= (parity_acc != data_in);
                state      <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_RD_WDOG_EN
  localparam logic [4:0] WARN_TH = 5'(WAIT_CYC - 1);

  logic [4:0] stall_cnt;

  // Stall watchdog: counts consecutive cycles where the FIFO holds data but
  // no read is issued. Any read, an empty FIFO or a soft reset restarts the
  // count; the counter saturates instead of wrapping so the warning holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (rd_en || !vld_out || soft_reset) begin
      stall_cnt <= '0;
    end else if (stall_cnt != 5'h1F) begin
      stall_cnt <= stall_cnt + 5'd1;
    end
  end

  assign stall_warn = (stall_cnt >= WARN_TH);
`else
  assign stall_warn = 1'b0;
`endif

endmodule

// File: tb/tb_router_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_router_rd_ctrl
//
// Self-checking bench for router_rd_ctrl. A queue models the port FIFO
// (one-cycle read latency) and a second queue holds the expected output
// events (start, payload byte, done, abort) in order. applyStimulus loads a
// packet into the FIFO model and pushes the events it should produce; the
// per-cycle monitor pops and compares every event the DUT emits.
// ---------------------------------------------------------------------------
module tb_router_rd_ctrl;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_DATA  = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;
  localparam logic [1:0] EV_ABORT = 2'd3;

`ifdef ROUTER_RD_WDOG_EN
  localparam logic WDOG_EXP = 1'b1;
`else
  localparam logic WDOG_EXP = 1'b0;
`endif

  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       vld_out;
  logic       soft_reset;
  logic [7:0] data_in;
  logic       sink_ready;
  logic       rd_en;
  logic [7:0] pkt_data;
  logic       pkt_data_vld;
  logic       pkt_start;
  logic [1:0] addr_out;
  logic [5:0] len_out;
  logic       pkt_done;
  logic       parity_err;
  logic       pkt_abort;
  logic       stall_warn;

  logic [7:0] fifo_q[$];
  ev_t        exp_q[$];
  int         checks;
  int         failures;
  int         reads;
  int         data_seen;
  int         sink_mode;

  router_rd_ctrl #(.DATA_W(8), .WAIT_CYC(30)) dut (
    .clk          (clk),
    .rst          (rst),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .data_in      (data_in),
    .sink_ready   (sink_ready),
    .rd_en        (rd_en),
    .pkt_data     (pkt_data),
    .pkt_data_vld (pkt_data_vld),
    .pkt_start    (pkt_start),
    .addr_out     (addr_out),
    .len_out      (len_out),
    .pkt_done     (pkt_done),
    .parity_err   (parity_err),
    .pkt_abort    (pkt_abort),
    .stall_warn   (stall_warn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Loads a packet into the FIFO model and queues the events it must cause.
  // bad_parity sends 8'h00 instead of the true parity. abort_after>0 means
  // the bench will soft-reset after that many payload bytes, so only the
  // start, those bytes and an abort are expected.
  task automatic applyStimulus(input logic [7:0] hdr, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input bit bad_parity,
                               input int abort_after);
    logic [7:0] pl [4];
    logic [7:0] par;
    logic [7:0] sent;
    int         len;
    pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3;
    len   = int'(hdr[7:2]);
    par   = hdr;
    fifo_q.push_back(hdr);
    exp_q.push_back('{kind: EV_START, val: hdr});
    for (int i = 0; i < len; i++) begin
      par = par ^ pl[i];
      fifo_q.push_back(pl[i]);
      if (abort_after == 0 || i < abort_after)
        exp_q.push_back('{kind: EV_DATA, val: pl[i]});
    end
    sent = bad_parity ? 8'h00 : par;
    fifo_q.push_back(sent);
    if (abort_after == 0)
      exp_q.push_back('{kind: EV_DONE, val: {7'd0, (sent != par)}});
    else
      exp_q.push_back('{kind: EV_ABORT, val: 8'h00});
  endtask

  task automatic expectEvent(input string tag, input logic [1:0] kind,
                             input logic [7:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_kind"}, 32'(kind), 32'(e.kind));
      checkOutput({tag, "_val"}, 32'(val), 32'(e.val));
    end
  endtask

  // Samples the registered outputs at the falling edge.
  task automatic monitor();
    if (pkt_start)    expectEvent("start", EV_START, {len_out, addr_out});
    if (pkt_data_vld) begin
      expectEvent("data", EV_DATA, pkt_data);
      data_seen++;
    end
    if (pkt_done)     expectEvent("done", EV_DONE, {7'd0, parity_err});
    if (pkt_abort)    expectEvent("abort", EV_ABORT, 8'h00);
  endtask

  // One clock cycle starting and ending at a falling edge: drive inputs,
  // note whether a read is requested, deliver FIFO data one cycle later.
  task automatic cycle();
    logic rd_seen;
    vld_out = (fifo_q.size() != 0);
    case (sink_mode)
      0:       sink_ready = 1'b1;
      1:       sink_ready = ~sink_ready;
      default: sink_ready = 1'b0;
    endcase
    #1;
    rd_seen = rd_en;
    @(posedge clk);
    #1;
    if (rd_seen) begin
      reads++;
      data_in = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'hEE;
    end else begin
      data_in = 8'hEE;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_events_left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_fifo_left"}, 32'(fifo_q.size()), 32'd0);
    repeat (3) cycle();
  endtask

  initial begin
    int r0;
    int n;
    checks     = 0;
    failures   = 0;
    reads      = 0;
    data_seen  = 0;
    sink_mode  = 0;
    rst        = 1'b1;
    vld_out    = 1'b0;
    soft_reset = 1'b0;
    data_in    = 8'h00;
    sink_ready = 1'b1;

    // Reset values with an empty FIFO
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_rd_en",      32'(rd_en),        32'd0);
    checkOutput("rst_pkt_data",   32'(pkt_data),     32'd0);
    checkOutput("rst_data_vld",   32'(pkt_data_vld), 32'd0);
    checkOutput("rst_pkt_start",  32'(pkt_start),    32'd0);
    checkOutput("rst_addr_out",   32'(addr_out),     32'd0);
    checkOutput("rst_len_out",    32'(len_out),      32'd0);
    checkOutput("rst_pkt_done",   32'(pkt_done),     32'd0);
    checkOutput("rst_parity_err", 32'(parity_err),   32'd0);
    checkOutput("rst_pkt_abort",  32'(pkt_abort),    32'd0);
    checkOutput("rst_stall_warn", 32'(stall_warn),   32'd0);
    @(negedge clk);

    // Basic packet, len 3, addr 1, correct parity
    applyStimulus(8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 0);
    drain("good_pkt", 40);
    checkOutput("good_addr", 32'(addr_out), 32'd1);
    checkOutput("good_len",  32'(len_out),  32'd3);

    // Bad parity followed back-to-back by a zero-length packet
    applyStimulus(8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 1'b1, 0);
    applyStimulus(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    drain("b2b_pkts", 60);
    checkOutput("len0_addr", 32'(addr_out), 32'd2);
    checkOutput("len0_len",  32'(len_out),  32'd0);

    // sink_ready toggling every cycle: order kept, exactly 5 reads
    r0        = reads;
    sink_mode = 1;
    applyStimulus(8'h0E, 8'hA1, 8'hB2, 8'hC3, 8'h00, 1'b0, 0);
    drain("toggle_pkt", 80);
    checkOutput("toggle_reads", 32'(reads - r0), 32'd5);
    sink_mode = 0;

    // soft_reset after the second payload byte of a len-4 packet
    data_seen = 0;
    applyStimulus(8'h10, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b0, 2);
    n = 0;
    while (data_seen < 2 && n < 40) begin
      cycle();
      n++;
    end
    checkOutput("abort_wait_bytes", 32'(data_seen), 32'd2);
    soft_reset = 1'b1;
    cycle();
    soft_reset = 1'b0;
    fifo_q.delete();
    checkOutput("abort_events_left", 32'(exp_q.size()), 32'd0);
    repeat (3) cycle();

    // soft_reset while idle blocks reads and pulses nothing; then a clean packet
    applyStimulus(8'h09, 8'h3C, 8'h4D, 8'h00, 8'h00, 1'b0, 0);
    soft_reset = 1'b1;
    vld_out    = 1'b1;
    sink_ready = 1'b1;
    #1;
    checkOutput("idle_soft_rd_en", 32'(rd_en), 32'd0);
    repeat (2) cycle();
    soft_reset = 1'b0;
    drain("after_abort_pkt", 40);

    // Stall: data waiting, sink not ready
    sink_mode = 2;
    applyStimulus(8'h05, 8'hE7, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    repeat (28) cycle();
    checkOutput("stall_28_warn", 32'(stall_warn), 32'd0);
    cycle();
    checkOutput("stall_29_warn", 32'(stall_warn), 32'(WDOG_EXP));
    sink_mode = 0;
    drain("stall_pkt", 40);
    checkOutput("stall_cleared", 32'(stall_warn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
